// File: rtl/hazard_fwd_ctrl_pkg.sv
// hazard_fwd_ctrl_pkg: Res class, forward-select, opcode and Tnew/Tuse tables shared by the hazard unit.
package hazard_fwd_ctrl_pkg;
    localparam int RES_W = 2;
    localparam int REG_W = 5;
    typedef enum logic [RES_W-1:0] {
        RES_NW  = 2'b00,
        RES_ALU = 2'b01,
        RES_DM  = 2'b10,
        RES_PC  = 2'b11
    } res_t;
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_E  = 2'b11;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;
    localparam logic [5:0] OP_R   = 6'd0;
    localparam logic [5:0] OP_BEQ = 6'd4;
    localparam logic [5:0] OP_LW  = 6'd35;
    localparam logic [5:0] OP_SW  = 6'd43;
    localparam logic [5:0] OP_ORI = 6'd13;
    localparam logic [5:0] OP_LUI = 6'd15;
    localparam logic [5:0] OP_JAL = 6'd3;
    localparam logic [5:0] FN_JR  = 6'd8;
    localparam logic [1:0] TUSE_BR  = 2'd0;
    localparam logic [1:0] TUSE_ALU = 2'd1;
    localparam logic [1:0] TUSE_ST  = 2'd2;
    function automatic logic [1:0] tnew_of(logic [RES_W-1:0] res);
        return res == RES_ALU ? 2'd1 : res == RES_DM ? 2'd2 : 2'd0;
    endfunction
    // $0 and no-write entries never match a source
    function automatic logic hit(logic [REG_W-1:0] r, logic [REG_W-1:0] dest, logic [RES_W-1:0] res);
        return r != '0 && dest == r && res != RES_NW;
    endfunction
endpackage

// File: rtl/hazard_fwd_ctrl_instr_class_decode.sv
// instr_class_decode: instruction -> source regs, destination, Res class and per-source Tuse.
module instr_class_decode
    import hazard_fwd_ctrl_pkg::*;
(
    input  logic [31:0]      instr,
    output logic [REG_W-1:0] rs,
    output logic [REG_W-1:0] rt,
    output logic [REG_W-1:0] dest,
    output logic [RES_W-1:0] res,
    output logic [1:0]       tuse_rs,
    output logic [1:0]       tuse_rt,
    output logic             use_rs,
    output logic             use_rt
);
    logic [5:0] op, fn;
    logic r_alu, jr, beq, lw, sw, ori, lui, jal;
    logic unused_shamt;
    assign op = instr[31:26];
    assign fn = instr[5:0];
    assign unused_shamt = ^instr[10:6];
    assign r_alu = op == OP_R && fn != FN_JR;
    assign jr    = op == OP_R && fn == FN_JR;
    assign beq   = op == OP_BEQ;
    assign lw    = op == OP_LW;
    assign sw    = op == OP_SW;
    assign ori   = op == OP_ORI;
    assign lui   = op == OP_LUI;
    assign jal   = op == OP_JAL;
    assign rs = instr[25:21];
    assign rt = instr[20:16];
    assign dest = r_alu ? instr[15:11] : (ori | lui | lw) ? rt : jal ? REG_W'(31) : '0;
    assign res = (r_alu | ori | lui) ? RES_ALU : lw ? RES_DM : jal ? RES_PC : RES_NW;
    assign use_rs = r_alu | jr | beq | ori | lw | sw;
    assign use_rt = r_alu | beq | sw;
    assign tuse_rs = (beq | jr) ? TUSE_BR : TUSE_ALU;
    assign tuse_rt = beq ? TUSE_BR : sw ? TUSE_ST : TUSE_ALU;
endmodule

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: E/M/W writer scoreboard driving RAW stall and all forwarding-mux selects.
module hazard_fwd_ctrl
    import hazard_fwd_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_d,
    output logic        stall,
    output logic [1:0]  fwd_rs_d,
    output logic [1:0]  fwd_rt_d,
    output logic [1:0]  fwd_rs_e,
    output logic [1:0]  fwd_rt_e,
    output logic        fwd_rt_m
);
    logic [REG_W-1:0] d_rs, d_rt, d_dest, rs_src, rt_src;
    logic [RES_W-1:0] d_res;
    logic [1:0]       tuse_rs, tuse_rt;
    logic             use_rs, use_rt;
    logic [REG_W-1:0] e_rs, e_rt, e_dest, m_rt, m_dest, w_dest;
    logic [RES_W-1:0] e_res, m_res, w_res;
    logic [1:0]       e_tnew, m_tnew;

    instr_class_decode u_dec (
        .instr(instr_d), .rs(d_rs), .rt(d_rt), .dest(d_dest), .res(d_res),
        .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .use_rs(use_rs), .use_rt(use_rt)
    );

    // unused source fields are zeroed so they can never stall or forward
    assign rs_src = use_rs ? d_rs : '0;
    assign rt_src = use_rt ? d_rt : '0;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            e_rs   <= '0;
            e_rt   <= '0;
            e_dest <= '0;
            e_res  <= RES_NW;
            e_tnew <= '0;
            m_rt   <= '0;
            m_dest <= '0;
            m_res  <= RES_NW;
            m_tnew <= '0;
            w_dest <= '0;
            w_res  <= RES_NW;
        end else begin
            e_rs   <= stall ? '0 : rs_src;
            e_rt   <= stall ? '0 : rt_src;
            e_dest <= stall ? '0 : d_dest;
            e_res  <= stall ? RES_NW : d_res;
            e_tnew <= stall ? 2'd0 : tnew_of(d_res);
            m_rt   <= e_rt;
            m_dest <= e_dest;
            m_res  <= e_res;
            m_tnew <= e_tnew != 2'd0 ? e_tnew - 2'd1 : 2'd0;
            w_dest <= m_dest;
            w_res  <= m_res;
        end

    assign stall = (hit(rs_src, e_dest, e_res) && e_tnew > tuse_rs)
                || (hit(rs_src, m_dest, m_res) && m_tnew > tuse_rs)
                || (hit(rt_src, e_dest, e_res) && e_tnew > tuse_rt)
                || (hit(rt_src, m_dest, m_res) && m_tnew > tuse_rt);

    assign fwd_rs_d = hit(rs_src, e_dest, e_res) && e_tnew == 2'd0 ? FWD_E
                    : hit(rs_src, m_dest, m_res) && m_tnew == 2'd0 ? FWD_M
                    : hit(rs_src, w_dest, w_res) ? FWD_W : FWD_RF;
    assign fwd_rt_d = hit(rt_src, e_dest, e_res) && e_tnew == 2'd0 ? FWD_E
                    : hit(rt_src, m_dest, m_res) && m_tnew == 2'd0 ? FWD_M
                    : hit(rt_src, w_dest, w_res) ? FWD_W : FWD_RF;
    assign fwd_rs_e = hit(e_rs, m_dest, m_res) && m_tnew == 2'd0 ? FWD_M
                    : hit(e_rs, w_dest, w_res) ? FWD_W : FWD_RF;
    assign fwd_rt_e = hit(e_rt, m_dest, m_res) && m_tnew == 2'd0 ? FWD_M
                    : hit(e_rt, w_dest, w_res) ? FWD_W : FWD_RF;
    assign fwd_rt_m = hit(m_rt, w_dest, w_res);
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb_hazard_fwd_ctrl: directed vector table, reset corner sequence and random stream vs an age-based pipeline model.
module tb_hazard_fwd_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr_d = '0;
    logic        stall, fwd_rt_m;
    logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    int checks = 0;
    int errors = 0;

    hazard_fwd_ctrl dut (
        .clk(clk), .reset(reset), .instr_d(instr_d), .stall(stall),
        .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e),
        .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m)
    );

    always #5 clk = ~clk;

    typedef enum int {K_NOP, K_ADDU, K_JR, K_BEQ, K_ORI, K_LUI, K_LW, K_SW, K_JAL} kind_t;
    // unused sources are 0; tnew is the cycles-until-ready count when the instr sits in EX
    typedef struct {
        logic [31:0] instr;
        int rs, rt, dest, tnew, tuse_rs, tuse_rt;
    } rec_t;
    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic [9:0]  exp;
    } vec_t;

    rec_t bubble = '{instr: '0, rs: 0, rt: 0, dest: 0, tnew: 0, tuse_rs: 0, tuse_rt: 0};
    rec_t pipe[3];
    vec_t tbl[21];

    function automatic rec_t mk(kind_t k, logic [4:0] a, logic [4:0] b, logic [4:0] c);
        rec_t r;
        r = '{instr: '0, rs: 0, rt: 0, dest: 0, tnew: 0, tuse_rs: 0, tuse_rt: 0};
        case (k)
            K_ADDU: begin r.instr = {6'd0, a, b, c, 5'd0, 6'h21}; r.rs = a; r.rt = b; r.dest = c;
                          r.tnew = 1; r.tuse_rs = 1; r.tuse_rt = 1; end
            K_JR:   begin r.instr = {6'd0, a, 15'd0, 6'd8}; r.rs = a; end
            K_BEQ:  begin r.instr = {6'd4, a, b, 16'h0003}; r.rs = a; r.rt = b; end
            K_ORI:  begin r.instr = {6'd13, a, b, 16'h0005}; r.rs = a; r.dest = b; r.tnew = 1; r.tuse_rs = 1; end
            K_LUI:  begin r.instr = {6'd15, a, b, 16'h1234}; r.dest = b; r.tnew = 1; end
            K_LW:   begin r.instr = {6'd35, a, b, 16'h0010}; r.rs = a; r.dest = b; r.tnew = 2; r.tuse_rs = 1; end
            K_SW:   begin r.instr = {6'd43, a, b, 16'h0010}; r.rs = a; r.rt = b; r.tuse_rs = 1; r.tuse_rt = 2; end
            K_JAL:  begin r.instr = {6'd3, 26'h0000123}; r.dest = 31; end
            default: r.instr = '0;
        endcase
        return r;
    endfunction

    function automatic logic [9:0] ex(logic st, logic [1:0] rsd, logic [1:0] rtd,
                                      logic [1:0] rse, logic [1:0] rte, logic m);
        return {st, rsd, rtd, rse, rte, m};
    endfunction

    function automatic int tn(int age);
        return pipe[age].tnew > age ? pipe[age].tnew - age : 0;
    endfunction

    function automatic logic blocks(int r, int t);
        if (r == 0) return 1'b0;
        for (int a = 0; a < 2; a++)
            if (pipe[a].dest == r && tn(a) > t) return 1'b1;
        return 1'b0;
    endfunction

    // nearest ready producer, searching from the stage just after the reader
    function automatic logic [1:0] src(int r, int from);
        logic [1:0] code [3];
        code[0] = 2'b11; code[1] = 2'b01; code[2] = 2'b10;
        if (r == 0) return 2'b00;
        for (int a = from; a < 3; a++)
            if (pipe[a].dest == r && tn(a) == 0) return code[a];
        return 2'b00;
    endfunction

    function automatic logic [9:0] model(rec_t d);
        logic m;
        m = pipe[2].dest != 0 && pipe[2].dest == pipe[1].rt;
        return {blocks(d.rs, d.tuse_rs) || blocks(d.rt, d.tuse_rt),
                src(d.rs, 0), src(d.rt, 0), src(pipe[0].rs, 1), src(pipe[0].rt, 1), m};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 3; i++) pipe[i] = bubble;
    endtask

    task automatic check(string name, logic [9:0] exp);
        logic [9:0] act;
        act = {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got stall/rsd/rtd/rse/rte/m=%b required %b", name, act, exp);
        end
    endtask

    function automatic logic [4:0] rr();
        int v;
        v = $urandom_range(0, 4);
        return v == 4 ? 5'd31 : 5'(v);
    endfunction

    initial begin
        rec_t cur;
        logic [9:0] e;
        tbl[0]  = '{1'b1, mk(K_LW, 0, 1, 0).instr,    ex(0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{1'b0, mk(K_ADDU, 1, 1, 2).instr,  ex(1, 0, 0, 0, 0, 0)};
        tbl[2]  = '{1'b0, mk(K_ADDU, 1, 1, 2).instr,  ex(0, 0, 0, 0, 0, 0)};
        tbl[3]  = '{1'b0, mk(K_NOP, 0, 0, 0).instr,   ex(0, 0, 0, 2'b10, 2'b10, 0)};
        tbl[4]  = '{1'b0, mk(K_LW, 0, 1, 0).instr,    ex(0, 0, 0, 0, 0, 0)};
        tbl[5]  = '{1'b0, mk(K_BEQ, 1, 1, 0).instr,   ex(1, 0, 0, 0, 0, 0)};
        tbl[6]  = '{1'b0, mk(K_BEQ, 1, 1, 0).instr,   ex(1, 0, 0, 0, 0, 0)};
        tbl[7]  = '{1'b0, mk(K_BEQ, 1, 1, 0).instr,   ex(0, 2'b10, 2'b10, 0, 0, 0)};
        tbl[8]  = '{1'b0, mk(K_ORI, 0, 3, 0).instr,   ex(0, 0, 0, 0, 0, 0)};
        tbl[9]  = '{1'b0, mk(K_SW, 0, 3, 0).instr,    ex(0, 0, 0, 0, 0, 0)};
        tbl[10] = '{1'b0, mk(K_NOP, 0, 0, 0).instr,   ex(0, 0, 0, 0, 2'b01, 0)};
        tbl[11] = '{1'b0, mk(K_NOP, 0, 0, 0).instr,   ex(0, 0, 0, 0, 0, 1)};
        tbl[12] = '{1'b0, mk(K_JAL, 0, 0, 0).instr,   ex(0, 0, 0, 0, 0, 0)};
        tbl[13] = '{1'b0, mk(K_JR, 31, 0, 0).instr,   ex(0, 2'b11, 0, 0, 0, 0)};
        tbl[14] = '{1'b0, mk(K_ORI, 0, 0, 0).instr,   ex(0, 0, 0, 2'b01, 0, 0)};
        tbl[15] = '{1'b0, mk(K_ADDU, 0, 0, 4).instr,  ex(0, 0, 0, 0, 0, 0)};
        tbl[16] = '{1'b0, mk(K_NOP, 0, 0, 0).instr,   ex(0, 0, 0, 0, 0, 0)};
        tbl[17] = '{1'b0, mk(K_LW, 0, 5, 0).instr,    ex(0, 0, 0, 0, 0, 0)};
        tbl[18] = '{1'b0, mk(K_SW, 0, 5, 0).instr,    ex(0, 0, 0, 0, 0, 0)};
        tbl[19] = '{1'b0, mk(K_NOP, 0, 0, 0).instr,   ex(0, 0, 0, 0, 0, 0)};
        tbl[20] = '{1'b0, mk(K_NOP, 0, 0, 0).instr,   ex(0, 0, 0, 0, 0, 1)};

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 21; i++) begin
            if (tbl[i].rst) begin reset = 1'b0; #1; reset = 1'b1; end
            instr_d = tbl[i].instr;
            @(negedge clk);
            check($sformatf("vec%0d", i), tbl[i].exp);
            @(posedge clk);
            #1;
        end

        // reset dropped in the first stall cycle of lw/beq, then released mid-cycle
        reset = 1'b0; #1; reset = 1'b1;
        instr_d = mk(K_LW, 0, 1, 0).instr;
        @(posedge clk); #1;
        instr_d = mk(K_BEQ, 1, 1, 0).instr;
        @(negedge clk);
        check("rst_pre_stall", ex(1, 0, 0, 0, 0, 0));
        #1 reset = 1'b0;
        #1 check("rst_mid_stall", ex(0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        check("rst_held", ex(0, 0, 0, 0, 0, 0));
        instr_d = mk(K_LW, 0, 1, 0).instr;
        reset = 1'b1;
        @(posedge clk); #1;
        instr_d = mk(K_ADDU, 1, 1, 2).instr;
        @(negedge clk);
        check("rst_release_load", ex(1, 0, 0, 0, 0, 0));
        @(posedge clk); #1;

        reset = 1'b0; #1; reset = 1'b1;
        clear_model();
        cur = mk(kind_t'($urandom_range(0, 8)), rr(), rr(), rr());
        for (int n = 0; n < 600; n++) begin
            instr_d = cur.instr;
            if ($urandom_range(0, 49) == 0) begin
                reset = 1'b0; #1; reset = 1'b1;
                clear_model();
            end
            @(negedge clk);
            e = model(cur);
            check($sformatf("rand%0d", n), e);
            @(posedge clk); #1;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = e[9] ? bubble : cur;
            if (!e[9]) cur = mk(kind_t'($urandom_range(0, 8)), rr(), rr(), rr());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
